// File: rtl/subleq_arg_unpacker_pkg.sv
// Shared definitions for subleq instruction assembly: default layout, argument
// naming, field bounds and the layout legality check used at elaboration.
package subleq_arg_unpacker_pkg;

  localparam int DEF_ARG_W    = 20;
  localparam int DEF_NUM_ARGS = 3;
  localparam int DEF_MEM_W    = 20;

  // One entry per argument of the default layout.
  typedef enum logic [1:0] {
    ARG_A = 2'd0,
    ARG_B = 2'd1,
    ARG_C = 2'd2
  } args_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic int arg_low_bound(input int i, input int arg_w = DEF_ARG_W);
    return i * arg_w;
  endfunction

  function automatic int arg_up_bound(input int i, input int arg_w = DEF_ARG_W);
    return (i + 1) * arg_w - 1;
  endfunction

  function automatic bit layout_ok(input int arg_w, input int num_args, input int mem_w);
    return (arg_w >= 1) && (num_args >= 1) && (mem_w >= 1) &&
           (((arg_w * num_args) % mem_w) == 0);
  endfunction

endpackage

// File: rtl/subleq_arg_unpacker.sv
// Collects BEATS narrow memory beats into one subleq instruction and hands the
// packed argument fields to the execute stage over a valid/ready interface.
module subleq_arg_unpacker
  import subleq_arg_unpacker_pkg::*;
#(
  parameter int  ARG_W    = DEF_ARG_W,
  parameter int  NUM_ARGS = DEF_NUM_ARGS,
  parameter int  MEM_W    = DEF_MEM_W,
  localparam int INSTR_W  = NUM_ARGS * ARG_W,
  localparam int BEATS    = INSTR_W / MEM_W,
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MEM_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_args,
  output logic [CNT_W-1:0]   beat_cnt
);

  if (!layout_ok(ARG_W, NUM_ARGS, MEM_W)) begin : g_bad_layout
    $error("subleq_arg_unpacker: illegal layout ARG_W=%0d NUM_ARGS=%0d MEM_W=%0d",
           ARG_W, NUM_ARGS, MEM_W);
  end

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] args_q, args_d;
  logic               accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      args_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      args_q  <= args_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    args_d  = args_q;
    if (flush) begin
      state_d = ST_FILL;
      cnt_d   = '0;
    end else begin
      // In HOLD cnt_q is 0, so a beat taken during the handshake lands in slot 0.
      for (int k = 0; k < BEATS; k++) begin
        if (accept && (cnt_q == CNT_W'(k))) begin
          args_d[k*MEM_W +: MEM_W] = in_data;
        end
      end
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (accept) begin
              if (BEATS == 1) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
              end else begin
                state_d = ST_FILL;
                cnt_d   = CNT_W'(1);
              end
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == ST_HOLD);
    in_ready  = 1'b0;
    if (!flush) begin
      in_ready = (state_q == ST_FILL) ? 1'b1 : out_ready;
    end
  end

  assign out_args = args_q;
  assign beat_cnt = cnt_q;

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(out_args));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    int'(beat_cnt) < BEATS);
`endif

endmodule

// File: tb/tb_subleq_arg_unpacker.sv
// Directed and random checks of the subleq argument unpacker: a cycle model
// tracks handshakes and a queue of expected instructions scores the output.
module tb_subleq_arg_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [19:0] in_data;
  logic [59:0] out_args;
  logic [1:0]  beat_cnt;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [29:0] w_in_data;
  logic [59:0] w_out_args;
  logic [0:0]  w_beat_cnt;

  subleq_arg_unpacker u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_args (out_args),
    .beat_cnt (beat_cnt)
  );

  subleq_arg_unpacker #(.ARG_W(20), .NUM_ARGS(3), .MEM_W(30)) u_dut_wide (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (w_in_valid),
    .in_ready (w_in_ready),
    .in_data  (w_in_data),
    .out_valid(w_out_valid),
    .out_ready(w_out_ready),
    .out_args (w_out_args),
    .beat_cnt (w_beat_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  logic [59:0] exp_q[$];
  logic [59:0] mbuf;
  int          mcnt, n_push, n_pop;
  int          base_push, base_pop, cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle model of the default instance: what the next edge must do.
  task automatic observe();
    logic        exp_ready;
    logic [59:0] e;
    exp_ready = !flush && ((exp_q.size() == 0) || out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("beat_cnt", 64'(beat_cnt), 64'(mcnt));
    if (flush) begin
      mcnt = 0;
      exp_q.delete();
    end else begin
      if (out_ready && (exp_q.size() != 0)) begin
        e = exp_q.pop_front();
        n_pop++;
        chk("out_args", 64'(out_args), 64'(e));
        $display("TXN %0d args=%h", n_pop, out_args);
      end
      if (in_valid && exp_ready) begin
        mbuf[mcnt*20 +: 20] = in_data;
        mcnt++;
        if (mcnt == 3) begin
          exp_q.push_back(mbuf);
          n_push++;
          mcnt = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [19:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;
    mcnt = 0; mbuf = '0; n_push = 0; n_pop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_out_args", 64'(out_args), 64'd0);
    chk("rst_w_out_valid", 64'(w_out_valid), 64'd0);
    chk("rst_w_out_args", 64'(w_out_args), 64'd0);
    rst = 1'b0;

    // Basic assembly, out_ready held high.
    beat(20'h00001);
    chk("t1_cnt1", 64'(beat_cnt), 64'd1);
    beat(20'h00002);
    chk("t1_cnt2", 64'(beat_cnt), 64'd2);
    beat(20'h00003);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_cnt0", 64'(beat_cnt), 64'd0);
    chk("t1_A", 64'(out_args[19:0]), 64'h00001);
    chk("t1_B", 64'(out_args[39:20]), 64'h00002);
    chk("t1_C", 64'(out_args[59:40]), 64'h00003);
    idle();
    chk("t1_consumed", 64'(out_valid), 64'd0);

    // Backpressure, then release with the next beat waiting.
    beat(20'h00004);
    beat(20'h00005);
    out_ready = 1'b0;
    beat(20'h00006);
    in_valid = 1'b1;
    in_data  = 20'hAAAAA;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_args", 64'(out_args), 64'({20'h00006, 20'h00005, 20'h00004}));
      chk("bp_cnt", 64'(beat_cnt), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_cnt", 64'(beat_cnt), 64'd1);
    chk("bp_rel_valid", 64'(out_valid), 64'd0);
    chk("bp_rel_beat0", 64'(out_args[19:0]), 64'hAAAAA);
    beat(20'hBBBBB);
    beat(20'hCCCCC);
    idle();

    // Flush during assembly.
    beat(20'h00011);
    beat(20'h00022);
    chk("fl_cnt2", 64'(beat_cnt), 64'd2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data  = 20'h00033;
    step();
    flush = 1'b0;
    chk("fl_cnt0", 64'(beat_cnt), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    beat(20'h00044);
    beat(20'h00055);
    beat(20'h00066);
    idle();

    // Flush while holding a completed instruction.
    beat(20'h00101);
    beat(20'h00102);
    out_ready = 1'b0;
    beat(20'h00103);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flh_valid", 64'(out_valid), 64'd0);
    idle();

    // Asynchronous reset between edges with one beat collected.
    beat(20'h00077);
    chk("ar_cnt1", 64'(beat_cnt), 64'd1);
    in_valid = 1'b1;
    in_data  = 20'h00088;
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt", 64'(beat_cnt), 64'd0);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_args", 64'(out_args), 64'd0);
    rst = 1'b0;
    mcnt = 0;
    exp_q.delete();
    step();
    beat(20'h00099);
    beat(20'h000AA);
    idle();

    // 30-bit beats carrying a 3 x 20-bit instruction.
    w_in_valid = 1'b1;
    w_in_data  = 30'h3FFFFFFF;
    step();
    chk("w_cnt1", 64'(w_beat_cnt), 64'd1);
    chk("w_mid_valid", 64'(w_out_valid), 64'd0);
    w_in_data = 30'h00000000;
    step();
    w_in_valid = 1'b0;
    chk("w_valid", 64'(w_out_valid), 64'd1);
    chk("w_A", 64'(w_out_args[19:0]), 64'hFFFFF);
    chk("w_B", 64'(w_out_args[39:20]), 64'h003FF);
    chk("w_C", 64'(w_out_args[59:40]), 64'h00000);
    $display("TXN wide args=%h", w_out_args);
    step();
    chk("w_consumed", 64'(w_out_valid), 64'd0);

    // Random streaming with random backpressure.
    base_push = n_push;
    base_pop  = n_pop;
    cyc = 0;
    while (((n_pop - base_pop) < 100) && (cyc < 5000)) begin
      in_valid  = ((n_push - base_push) < 100) && ($urandom_range(0, 9) < 8);
      in_data   = 20'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rand_popped", 64'(n_pop - base_pop), 64'd100);
    chk("rand_pushed", 64'(n_push - base_push), 64'd100);
    chk("rand_left", 64'(exp_q.size()), 64'd0);
    chk("rand_idle_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subleq_arg_unpacker.md
Name: subleq_arg_unpacker

Overview:
- Assembles one subleq instruction from a stream of narrow memory beats, then presents its operand fields (A, B, C, ...) on a valid/ready output.
- Sits between the instruction-memory read port and the execute stage.
- Parametrised successor of the fixed three-field, 20-bit argument layout: argument width, argument count and beat width are generics.
- Adds flush handling and a field-overflow-free layout check.

Parameters:
- ARG_W, 20, width in bits of each instruction argument.
- NUM_ARGS, 3, arguments per instruction (A, B, C, ...).
- MEM_W, 20, width of one memory beat; NUM_ARGS*ARG_W must be an integer multiple of MEM_W.
- Derived (localparam): INSTR_W = NUM_ARGS*ARG_W; BEATS = INSTR_W/MEM_W; CNT_W = max(1, $clog2(BEATS)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of any partially assembled or held instruction.
- in_valid  in  1  beat valid.
- in_ready  out  1  unpacker accepts beat this cycle.
- in_data  in  MEM_W  beat payload.
- out_valid  out  1  complete instruction available.
- out_ready  in  1  consumer accepts instruction.
- out_args  out  INSTR_W  packed arguments; arg i occupies [i*ARG_W +: ARG_W] (A = arg 0 at bit 0).
- beat_cnt  out  CNT_W  beats collected for current instruction (status).

Behaviour:
- Reset (async assert): state FILL, beat_cnt = 0, out_valid = 0, out_args = 0. in_ready = 1 after reset deasserts.
- Beat packing, little-endian: beat k of an instruction is written to out_args[k*MEM_W +: MEM_W]. Bits not yet written keep their previous contents.
- State FILL:
  - in_ready = 1.
  - On accept (in_valid & in_ready) with beat_cnt < BEATS-1: store beat, beat_cnt++.
  - On accept with beat_cnt == BEATS-1: store beat, beat_cnt -> 0, out_valid -> 1, state -> HOLD.
- State HOLD:
  - out_valid = 1; out_args stable until the handshake.
  - in_ready = out_ready, so the next instruction's first beat can be taken in the same cycle the current one is consumed.
  - On out_valid & out_ready: if a beat is also accepted, it is stored as beat 0 of the next instruction and beat_cnt -> 1 (or straight back to HOLD when BEATS == 1). Otherwise out_valid -> 0 and state -> FILL.
  - out_valid & !out_ready: hold everything; no beat accepted.
- Latency: out_valid rises the cycle after the last beat is accepted. Throughput is one instruction per BEATS cycles with no bubbles.
- BEATS == 1: every accepted beat produces an instruction next cycle; full throughput with out_ready held high.
- flush (priority over all handshakes in that cycle): beat_cnt -> 0, out_valid -> 0, state -> FILL. Any beat presented that cycle is not accepted (in_ready forced 0). out_args contents are don't-care.
- rst mid-instruction discards partial data immediately (async).
- Width/legality: elaboration-time $error if INSTR_W % MEM_W != 0, ARG_W < 1, or NUM_ARGS < 1.
- Assertions (simulation only):
  - out_args stable while out_valid & !out_ready.
  - beat_cnt never exceeds BEATS-1.

Decomposition:
- Shared package gc:
  - ARGS enum extended to NUM_ARGS entries.
  - Default ARG_W / NUM_ARGS / MEM_W constants.
  - Functions arg_low_bound(i) = i*ARG_W and arg_up_bound(i) = (i+1)*ARG_W-1, parametrised so execute-stage field extraction shares one definition.
- utils keeps the _assert helper, reused for the legality checks.
- No sub-module; one FSM plus counter is natural. The beat counter may be a local always block.

Test Plan:
- Defaults (20/3/20), out_ready = 1: beats 0x00001, 0x00002, 0x00003 on consecutive cycles -> out_valid high 1 cycle after the third beat; A = 0x00001, B = 0x00002, C = 0x00003; beat_cnt sequence 0, 1, 2, 0.
- Backpressure: out_ready = 0 for 4 cycles after the instruction completes -> out_valid held, out_args stable, in_ready = 0. Release with next beat 0xAAAAA present -> instruction consumed and 0xAAAAA captured as beat 0 in the same cycle; beat_cnt = 1.
- MEM_W = 30, ARG_W = 20, NUM_ARGS = 3: beats 0x3FFFFFFF, 0x00000000 -> A = 0xFFFFF, B = 0x003FF, C = 0x00000.
- flush asserted with beat_cnt = 2 and in_valid = 1 -> beat not taken, beat_cnt = 0, out_valid = 0. The next three beats form a clean instruction.
- rst pulsed asynchronously mid-beat (between edges) while beat_cnt = 1 -> outputs reset immediately; after release, the next three beats form a correct instruction.
- Back-to-back streaming of 100 random instructions with random out_ready -> scoreboard shows zero loss or duplication, and output order matches input order.
